uart_tx_fifo: RTL and testbench

Parametrised successor to the single-byte UART transmitter. It adds a TX FIFO and a runtime baud divisor, plus runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Frames are sent back-to-back with no idle gap while the FIFO holds data. It sits between the core's peripheral bus bridge and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO, a runtime baud divisor, runtime parity
// (none/even/odd) and 1 or 2 stop bits. Frames go out back-to-back while
// the FIFO holds data.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i, data_i        write request and word; push when valid_i && ready_o
//   ready_o                FIFO not full
//   div_i                  clocks per bit (0 behaves as 1), latched per frame
//   parity_i               00 none, 01 even, 10 odd, 11 none; latched per frame
//   stop2_i                1 = two stop bits; latched per frame
//   tx_o                   serial line, idle high
//   busy_o                 frame engine not idle
//   level_o                FIFO occupancy
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    output logic                          ready_o,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic [1:0]                    parity_i,
    input  logic                          stop2_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_ready;

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div_m1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_bit_idx;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_left;
    logic                  r_tx;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_empty;
    logic                  w_bit_end;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DIV_WIDTH-1:0]  w_div_m1;
    logic [LW-1:0]         w_level_nxt;

    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  w_cnt_nxt;
    logic [DIV_WIDTH-1:0]  w_div_m1_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]         w_bit_idx_nxt;
    logic                  w_par_en_nxt;
    logic                  w_par_bit_nxt;
    logic                  w_stop2_nxt;
    logic                  w_stop_left_nxt;
    logic                  w_tx_nxt;

    assign w_push      = valid_i && r_ready;
    assign w_empty     = (r_level == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_div_m1    = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
    assign w_bit_end   = (r_cnt == '0);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // FIFO pointers and occupancy; ready follows the next level so a pop
    // while full re-opens the FIFO one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
        end
    end

    // Frame engine state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div_m1    <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_left <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div_m1    <= w_div_m1_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_par_en    <= w_par_en_nxt;
            r_par_bit   <= w_par_bit_nxt;
            r_stop2     <= w_stop2_nxt;
            r_stop_left <= w_stop_left_nxt;
            r_tx        <= w_tx_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Frame engine next-state and line value
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_div_m1_nxt    = r_div_m1;
        w_shift_nxt     = r_shift;
        w_bit_idx_nxt   = r_bit_idx;
        w_par_en_nxt    = r_par_en;
        w_par_bit_nxt   = r_par_bit;
        w_stop2_nxt     = r_stop2;
        w_stop_left_nxt = r_stop_left;
        w_tx_nxt        = r_tx;
        w_load          = 1'b0;
        w_pop           = 1'b0;

        if (r_state != S_IDLE && !w_bit_end) begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tx_nxt = 1'b1;
                    w_load   = !w_empty;
                end
                S_START: begin
                    w_state_nxt   = S_DATA;
                    w_cnt_nxt     = r_div_m1;
                    w_tx_nxt      = r_shift[0];
                    w_bit_idx_nxt = '0;
                end
                S_DATA: begin
                    w_cnt_nxt = r_div_m1;
                    if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt     = S_STOP;
                            w_tx_nxt        = 1'b1;
                            w_stop_left_nxt = r_stop2;
                        end
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[DATA_WIDTH-1:1]};
                        w_tx_nxt      = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end
                end
                S_PARITY: begin
                    w_state_nxt     = S_STOP;
                    w_cnt_nxt       = r_div_m1;
                    w_tx_nxt        = 1'b1;
                    w_stop_left_nxt = r_stop2;
                end
                S_STOP: begin
                    if (r_stop_left) begin
                        w_stop_left_nxt = 1'b0;
                        w_cnt_nxt       = r_div_m1;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end

        // Start a frame: pop the head word and latch this frame's config
        if (w_load) begin
            w_pop         = 1'b1;
            w_state_nxt   = S_START;
            w_tx_nxt      = 1'b0;
            w_cnt_nxt     = w_div_m1;
            w_div_m1_nxt  = w_div_m1;
            w_shift_nxt   = w_head;
            w_bit_idx_nxt = '0;
            w_par_en_nxt  = (parity_i == 2'b01) || (parity_i == 2'b10);
            w_par_bit_nxt = (^w_head) ^ (parity_i == 2'b10);
            w_stop2_nxt   = stop2_i;
        end
    end

    assign ready_o = r_ready;
    assign tx_o    = r_tx;
    assign busy_o  = r_busy;
    assign level_o = r_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DATA_WIDTH=8, FIFO_DEPTH=4, DIV_WIDTH=16).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_uart_tx_fifo;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        ready_o;
    logic [15:0] div_i;
    logic [1:0]  parity_i;
    logic        stop2_i;
    logic        tx_o;
    logic        busy_o;
    logic [2:0]  level_o;

    int n_tests;
    int n_fail;

    // Simple line receiver (parity none, one stop bit), used for the FIFO test
    bit         rx_en;
    int         rx_p;
    int         rx_cnt;
    bit         rx_act;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .DIV_WIDTH (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .div_i   (div_i),
        .parity_i(parity_i),
        .stop2_i (stop2_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rx_en) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_o === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % rx_p) == 0 && (rx_cnt / rx_p) >= 1 && (rx_cnt / rx_p) <= 8)
                rx_byte[(rx_cnt / rx_p) - 1] = tx_o;
            if (rx_cnt == 10 * rx_p - 1) begin
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Walk one frame cycle by cycle; bits[0] is the start bit
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                               input int p, input int lvl0, input int chg_at,
                               input logic [15:0] chg_div);
        for (int i = 0; i < nbits * p; i++) begin
            tick();
            if (i == 0) begin
                valid_i = 1'b0;
                check($sformatf("%s_lvl0", tag), 32'(level_o), 32'(lvl0));
            end
            if (i == chg_at) div_i = chg_div;
            check($sformatf("%s_tx_c%0d", tag, i), 32'(tx_o), 32'(bits[i / p]));
            check($sformatf("%s_busy_c%0d", tag, i), 32'(busy_o), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        tick();
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_tx"}, 32'(tx_o), 32'd1);
    endtask

    task automatic push_one(input logic [7:0] d);
        data_i  = d;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        int lvl_fill [8];
        int rdy_fill [8];
        int lvl_tail [5];
        int rdy_tail [5];
        int waited;

        lvl_fill = '{1, 1, 2, 3, 4, 4, 4, 4};
        rdy_fill = '{1, 1, 1, 1, 0, 0, 0, 0};
        lvl_tail = '{4, 4, 4, 3, 4};
        rdy_tail = '{0, 0, 0, 1, 0};

        n_tests  = 0;
        n_fail   = 0;
        rx_en    = 1'b0;
        rx_p     = 1;
        rst_ni   = 1'b1;
        valid_i  = 1'b0;
        data_i   = 8'h00;
        div_i    = 16'd4;
        parity_i = 2'b00;
        stop2_i  = 1'b0;

        // Reset state
        #1 rst_ni = 1'b0;
        #2;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        #20 rst_ni = 1'b1;
        tick();
        tick();
        check("post_rst_tx", 32'(tx_o), 32'd1);

        // 1: basic frame 0xA5, P=4
        push_one(8'hA5);
        check("t1_push_level", 32'(level_o), 32'd1);
        check("t1_push_busy", 32'(busy_o), 32'd0);
        check("t1_push_tx", 32'(tx_o), 32'd1);
        check_frame("t1", 16'b1101001010, 10, 4, 0, -1, 16'd0);
        check_idle("t1_end");

        // 2: parity and stop bits with P=2, data 0x07 (XOR of bits = 1)
        div_i    = 16'd2;
        parity_i = 2'b01;
        push_one(8'h07);
        check_frame("t2_even", 16'b11000001110, 11, 2, 0, -1, 16'd0);
        check_idle("t2_even_end");
        parity_i = 2'b10;
        push_one(8'h07);
        check_frame("t2_odd", 16'b10000001110, 11, 2, 0, -1, 16'd0);
        check_idle("t2_odd_end");
        parity_i = 2'b01;
        stop2_i  = 1'b1;
        push_one(8'h07);
        check_frame("t2_stop2", 16'b111000001110, 12, 2, 0, -1, 16'd0);
        check_idle("t2_stop2_end");
        parity_i = 2'b00;
        stop2_i  = 1'b0;

        // 3: FIFO fill with P=1; valid held 8 cycles with 0x10..0x17
        div_i = 16'd1;
        rx_p  = 1;
        rx_q.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_i  = 8'(8'h10 + i);
            valid_i = 1'b1;
            tick();
            check($sformatf("t3_fill_lvl%0d", i), 32'(level_o), 32'(lvl_fill[i]));
            check($sformatf("t3_fill_rdy%0d", i), 32'(ready_o), 32'(rdy_fill[i]));
        end
        // keep offering 0x15; it lands the cycle after the second frame starts
        data_i = 8'h15;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_tail_lvl%0d", i), 32'(level_o), 32'(lvl_tail[i]));
            check($sformatf("t3_tail_rdy%0d", i), 32'(ready_o), 32'(rdy_tail[i]));
        end
        valid_i = 1'b0;
        waited  = 0;
        while ((busy_o !== 1'b0 || level_o !== 3'd0) && waited < 200) begin
            tick();
            waited++;
        end
        check("t3_drain_busy", 32'(busy_o), 32'd0);
        tick();
        rx_en = 1'b0;
        check("t3_rx_count", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size())
                check($sformatf("t3_rx%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));
            else
                check($sformatf("t3_rx%0d", i), 32'hFFFF_FFFF, 32'(8'h10 + i));
        end

        // 4: back-to-back 0x55 then 0xAA, P=3
        div_i   = 16'd3;
        data_i  = 8'h55;
        valid_i = 1'b1;
        tick();
        data_i  = 8'hAA;
        check_frame("t4_a", 16'b1010101010, 10, 3, 1, -1, 16'd0);
        check_frame("t4_b", 16'b1101010100, 10, 3, 0, -1, 16'd0);
        check_idle("t4_end");

        // 5: divisor change mid-frame, then divisor 0
        div_i   = 16'd4;
        data_i  = 8'h3C;
        valid_i = 1'b1;
        tick();
        data_i  = 8'hC3;
        check_frame("t5_p4", 16'b1001111000, 10, 4, 1, 10, 16'd8);
        check_frame("t5_p8", 16'b1110000110, 10, 8, 0, -1, 16'd0);
        check_idle("t5_p8_end");
        div_i = 16'd0;
        push_one(8'h5A);
        check_frame("t5_p1", 16'b1010110100, 10, 1, 0, -1, 16'd0);
        check_idle("t5_p1_end");

        // 6: reset during DATA with two words queued
        div_i   = 16'd4;
        data_i  = 8'h81;
        valid_i = 1'b1;
        tick();
        data_i  = 8'h42;
        tick();
        data_i  = 8'h24;
        tick();
        valid_i = 1'b0;
        check("t6_queued", 32'(level_o), 32'd2);
        repeat (6) tick();
        check("t6_busy_before", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx_o), 32'd1);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_level", 32'(level_o), 32'd0);
        check("t6_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("t6_quiet_tx%0d", i), 32'(tx_o), 32'd1);
            check($sformatf("t6_quiet_busy%0d", i), 32'(busy_o), 32'd0);
        end
        check("t6_quiet_level", 32'(level_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
